// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue between the PC generator and the decoder.
//
// Accepts fetch PCs, issues instruction-memory requests (req/gnt + rvalid) and
// keeps PC/instruction pairs in an in-order queue that the decoder drains with a
// valid/ready handshake. A redirect (flush_i) discards queued and in-flight fetches.
//
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   pc_valid_i, pc_i, pc_ready_o   fetch PC handshake from the PC generator
//   flush_i                        redirect, drops queue and in-flight fetches
//   imem_req_o, imem_addr_o        memory request / address
//   imem_gnt_i                     request granted
//   imem_rvalid_i, imem_rdata_i,   read response (in grant order)
//   imem_err_i
//   inst_valid_o, inst_o,          head entry towards the decoder
//   inst_pc_o, inst_err_o,
//   inst_ready_i
module ifetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        pc_valid_i,
  input  logic [31:0] pc_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_err_o,
  input  logic        inst_ready_i
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = $clog2(2 * DEPTH) + 1;
  localparam logic [31:0] Nop = 32'h0000_0013;

  // Slots are kept in three contiguous regions of a circular buffer:
  //   [r_rptr, r_fptr) FILLED, [r_fptr, r_wptr) ALLOC, the rest FREE.
  // Responses arrive in grant order and misaligned entries are only inserted when
  // no slot is ALLOC, so a single fill pointer always names the oldest ALLOC slot.
  logic [PW:0]       r_wptr;
  logic [PW:0]       r_fptr;
  logic [PW:0]       r_rptr;
  logic [DW-1:0]     r_drop_cnt;
  logic [31:0]       r_pc   [DEPTH];
  logic [31:0]       r_inst [DEPTH];
  logic [DEPTH-1:0]  r_err;

  logic [PW:0]   w_n_alloc;
  logic          w_full;
  logic          w_credit;
  logic          w_has_alloc;
  logic          w_aligned;
  logic          w_alloc;
  logic          w_mis;
  logic          w_drop_pend;
  logic          w_rv_drop;
  logic          w_fill;
  logic          w_rv_counted;
  logic          w_pop;
  logic [DW-1:0] w_drop_flush;

  assign w_n_alloc   = r_wptr - r_fptr;
  assign w_full      = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_credit    = ~w_full;
  assign w_has_alloc = (r_wptr != r_fptr);
  assign w_aligned   = (pc_i[1:0] == 2'b00);

  assign imem_req_o  = rstn_i & pc_valid_i & w_aligned & w_credit & ~flush_i;
  assign imem_addr_o = pc_i;
  assign w_alloc     = imem_req_o & imem_gnt_i;
  // Misaligned PCs bypass memory; held off behind ALLOC slots to keep order.
  assign w_mis       = rstn_i & pc_valid_i & ~w_aligned & w_credit & ~w_has_alloc & ~flush_i;
  assign pc_ready_o  = w_alloc | w_mis;

  assign w_drop_pend  = (r_drop_cnt != '0);
  assign w_rv_drop    = imem_rvalid_i & w_drop_pend;
  assign w_fill       = imem_rvalid_i & ~w_drop_pend & w_has_alloc & ~flush_i;
  // An rvalid with nothing outstanding is a protocol violation and is ignored.
  assign w_rv_counted = imem_rvalid_i & (w_drop_pend | w_has_alloc);
  assign w_drop_flush = r_drop_cnt + {{(DW - PW - 1){1'b0}}, w_n_alloc}
                        - {{(DW - 1){1'b0}}, w_rv_counted};

  assign inst_valid_o = (r_rptr != r_fptr);
  assign inst_o       = r_inst[r_rptr[PW-1:0]];
  assign inst_pc_o    = r_pc[r_rptr[PW-1:0]];
  assign inst_err_o   = r_err[r_rptr[PW-1:0]];
  assign w_pop        = inst_valid_o & inst_ready_i & ~flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr     <= '0;
      r_fptr     <= '0;
      r_rptr     <= '0;
      r_drop_cnt <= '0;
    end else if (flush_i) begin
      r_rptr     <= r_wptr;
      r_fptr     <= r_wptr;
      r_drop_cnt <= w_drop_flush;
    end else begin
      r_wptr <= r_wptr + {{PW{1'b0}}, (w_alloc | w_mis)};
      r_fptr <= r_fptr + {{PW{1'b0}}, (w_fill | w_mis)};
      r_rptr <= r_rptr + {{PW{1'b0}}, w_pop};
      if (w_rv_drop) begin
        r_drop_cnt <= r_drop_cnt - {{(DW - 1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
      r_err <= '0;
    end else if (!flush_i) begin
      if (w_alloc) begin
        r_pc[r_wptr[PW-1:0]] <= pc_i;
      end
      if (w_mis) begin
        r_pc[r_wptr[PW-1:0]]   <= pc_i;
        r_inst[r_wptr[PW-1:0]] <= Nop;
        r_err[r_wptr[PW-1:0]]  <= 1'b1;
      end
      if (w_fill) begin
        r_inst[r_fptr[PW-1:0]] <= imem_err_i ? Nop : imem_rdata_i;
        r_err[r_fptr[PW-1:0]]  <= imem_err_i;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        pc_valid_i;
  logic [31:0] pc_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_err_o;
  logic        inst_ready_i;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn_i),
    .pc_valid_i   (pc_valid_i),
    .pc_i         (pc_i),
    .pc_ready_o   (pc_ready_o),
    .flush_i      (flush_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .imem_err_i   (imem_err_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_err_o   (inst_err_o),
    .inst_ready_i (inst_ready_i)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic        auto_mem;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic void push_exp(logic [31:0] pc, logic [31:0] inst, logic err);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.err = err;
    exp_q.push_back(e);
  endfunction

  // Monitor: every decoder pop is compared against the next expected entry.
  always @(negedge clk) begin
    if (rstn_i && inst_valid_o && inst_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h, expected no entry", inst_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pop_pc", inst_pc_o, e.pc);
        check("pop_inst", inst_o, e.inst);
        check("pop_err", {31'd0, inst_err_o}, {31'd0, e.err});
      end
    end
  end

  // Drive the auto-responder (1-cycle latency) and let combinational outputs settle.
  task automatic prep();
    if (auto_mem) begin
      if (pend_q.size() > 0) begin
        logic [31:0] a;
        a = pend_q.pop_front();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(a);
        imem_err_i    = (a == 32'h20);
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        imem_err_i    = 1'b0;
      end
    end
    #1;
  endtask

  task automatic clk_step();
    logic        g;
    logic [31:0] a;
    g = imem_req_o & imem_gnt_i;
    a = imem_addr_o;
    @(posedge clk);
    #1;
    if (auto_mem && g) pend_q.push_back(a);
  endtask

  task automatic tick();
    prep();
    clk_step();
  endtask

  task automatic drain(string name);
    int k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      tick();
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int k;
    logic [31:0] plist [5];

    auto_mem      = 1'b1;
    rstn_i        = 1'b0;
    pc_valid_i    = 1'b1;
    pc_i          = 32'h0;
    flush_i       = 1'b0;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    inst_ready_i  = 1'b1;
    #12;
    check("rst_inst_valid", {31'd0, inst_valid_o}, 0);
    check("rst_req", {31'd0, imem_req_o}, 0);
    check("rst_pc_ready", {31'd0, pc_ready_o}, 0);
    check("rst_inst", inst_o, 0);
    check("rst_inst_pc", inst_pc_o, 0);
    check("rst_inst_err", {31'd0, inst_err_o}, 0);
    pc_valid_i = 1'b0;
    @(negedge clk);
    rstn_i = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait streaming of PCs 0, 4, 8.
    for (int i = 0; i < 3; i++) push_exp(i * 4, mem_word(i * 4), 1'b0);
    for (int i = 0; i < 3; i++) begin
      pc_valid_i = 1'b1;
      pc_i = i * 4;
      prep();
      check("t1_req", {31'd0, imem_req_o}, 1);
      check("t1_pc_ready", {31'd0, pc_ready_o}, 1);
      clk_step();
      if (i == 0) check("t1_latency_early", {31'd0, inst_valid_o}, 0);
      if (i == 1) check("t1_first_pc", inst_pc_o, 32'h0);
      if (i == 2) check("t1_second_pc", inst_pc_o, 32'h4);
    end
    pc_valid_i = 1'b0;
    tick();
    check("t1_third_pc", inst_pc_o, 32'h8);
    drain("t1_drain");

    // Backpressure: only DEPTH fetches accepted while the decoder stalls.
    inst_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      plist[i] = 32'h100 + i * 4;
      push_exp(plist[i], mem_word(plist[i]), 1'b0);
    end
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      pc_valid_i = 1'b1;
      pc_i = plist[idx];
      prep();
      if (pc_ready_o) idx++;
      clk_step();
    end
    check("t2_grants", idx, 4);
    pc_i = plist[4];
    prep();
    check("t2_fifth_ready", {31'd0, pc_ready_o}, 0);
    check("t2_fifth_req", {31'd0, imem_req_o}, 0);
    clk_step();
    inst_ready_i = 1'b1;
    k = 0;
    while (idx < 5 && k < 10) begin
      prep();
      if (pc_ready_o) idx++;
      clk_step();
      k++;
    end
    check("t2_fifth_accepted", idx, 5);
    pc_valid_i = 1'b0;
    drain("t2_drain");

    // Bus error at 0x20.
    push_exp(32'h20, Nop, 1'b1);
    pc_valid_i = 1'b1;
    pc_i = 32'h20;
    tick();
    pc_valid_i = 1'b0;
    drain("t3_drain");
    tick();

    // Flush with two fetches in flight; their responses must be dropped.
    auto_mem = 1'b0;
    imem_rvalid_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h10;
    tick();
    pc_i = 32'h14;
    tick();
    pc_i = 32'h18;
    flush_i = 1'b1;
    prep();
    check("t4_flush_req", {31'd0, imem_req_o}, 0);
    check("t4_flush_ready", {31'd0, pc_ready_o}, 0);
    clk_step();
    flush_i = 1'b0;
    pc_valid_i = 1'b0;
    check("t4_empty", {31'd0, inst_valid_o}, 0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h0000_AAAA;
    tick();
    imem_rdata_i = 32'h0000_BBBB;
    tick();
    imem_rvalid_i = 1'b0;
    check("t4_dropped", {31'd0, inst_valid_o}, 0);
    push_exp(32'h40, 32'h1234_5678, 1'b0);
    pc_valid_i = 1'b1;
    pc_i = 32'h40;
    tick();
    pc_valid_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'h1234_5678;
    tick();
    imem_rvalid_i = 1'b0;
    check("t4_new_valid", {31'd0, inst_valid_o}, 1);
    drain("t4_drain");

    // Misaligned PC held behind an outstanding fetch.
    push_exp(32'h30, 32'hCAFE_F00D, 1'b0);
    push_exp(32'h22, Nop, 1'b1);
    pc_valid_i = 1'b1;
    pc_i = 32'h30;
    tick();
    pc_i = 32'h22;
    prep();
    check("t5_held_ready", {31'd0, pc_ready_o}, 0);
    check("t5_held_req", {31'd0, imem_req_o}, 0);
    clk_step();
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hCAFE_F00D;
    prep();
    check("t5_fill_cycle_ready", {31'd0, pc_ready_o}, 0);
    clk_step();
    imem_rvalid_i = 1'b0;
    prep();
    check("t5_accept_ready", {31'd0, pc_ready_o}, 1);
    check("t5_accept_req", {31'd0, imem_req_o}, 0);
    clk_step();
    pc_valid_i = 1'b0;
    drain("t5_drain");

    // Full queue, then pop + rvalid + flush in one cycle.
    inst_ready_i = 1'b0;
    pc_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_i = 32'h50 + i * 4;
      tick();
    end
    pc_valid_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hD000_0050;
    tick();
    imem_rdata_i = 32'hD000_0054;
    tick();
    imem_rvalid_i = 1'b0;
    pc_valid_i = 1'b1;
    pc_i = 32'h60;
    prep();
    check("t6_full_req", {31'd0, imem_req_o}, 0);
    push_exp(32'h50, 32'hD000_0050, 1'b0);
    inst_ready_i = 1'b1;
    prep();
    check("t6_full_pop_req", {31'd0, imem_req_o}, 0);
    clk_step();
    pc_valid_i = 1'b0;
    flush_i = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hD000_0058;
    tick();
    flush_i = 1'b0;
    check("t6_empty", {31'd0, inst_valid_o}, 0);
    imem_rdata_i = 32'hD000_005C;
    tick();
    imem_rvalid_i = 1'b0;
    push_exp(32'h60, 32'hD000_0060, 1'b0);
    pc_valid_i = 1'b1;
    pc_i = 32'h60;
    tick();
    pc_valid_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = 32'hD000_0060;
    tick();
    imem_rvalid_i = 1'b0;
    drain("t6_drain");

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
